// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, hides the one-cycle memory read latency and
// feeds decode through a 2-entry skid buffer. Optional FETCH_STALL_CNT_EN adds stall_count.
module fetch_unit #(
    parameter int          DATA_WIDTH = 12,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
`ifdef FETCH_STALL_CNT_EN
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [15:0]           stall_count
`else
    output logic [DATA_WIDTH-1:0] instr_pc
`endif
);

    localparam logic [DATA_WIDTH-1:0] RESET_ADDR = DATA_WIDTH'(RESET_PC);

    logic [DATA_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [DATA_WIDTH-1:0] inflight_pc_reg, inflight_pc_next;
    logic                  inflight_reg, inflight_next;
    logic [1:0]            count_reg, count_next;
    logic [DATA_WIDTH-1:0] word_reg [2];
    logic [DATA_WIDTH-1:0] word_next [2];
    logic [DATA_WIDTH-1:0] slot_pc_reg [2];
    logic [DATA_WIDTH-1:0] slot_pc_next [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic       wr_idx;
    logic [2:0] occupancy;

    assign mem_addr    = fetch_pc_reg;
    assign instr_valid = (count_reg != 2'd0);
    assign instr       = word_reg[0];
    assign instr_pc    = slot_pc_reg[0];

    // Credit check counts the word still in flight so a push always finds a free slot.
    always_comb begin
        pop       = instr_valid & instr_ready;
        push      = inflight_reg;
        occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
        issue     = !halt && !redirect_valid && (occupancy < 3'd2);
        wr_idx    = (count_reg == 2'd2) || ((count_reg == 2'd1) && !pop);
    end

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_pc_next = inflight_pc_reg;
        inflight_next    = 1'b0;
        count_next       = count_reg;
        for (int i = 0; i < 2; i++) begin
            word_next[i]    = word_reg[i];
            slot_pc_next[i] = slot_pc_reg[i];
        end

        if (redirect_valid) begin
            count_next    = 2'd0;
            fetch_pc_next = redirect_pc;
        end else begin
            if (pop) begin
                word_next[0]    = word_reg[1];
                slot_pc_next[0] = slot_pc_reg[1];
            end
            if (push) begin
                word_next[wr_idx]    = mem_data;
                slot_pc_next[wr_idx] = inflight_pc_reg;
            end
            count_next    = count_reg + {1'b0, push} - {1'b0, pop};
            inflight_next = issue;
            if (issue) begin
                inflight_pc_next = fetch_pc_reg;
                fetch_pc_next    = fetch_pc_reg + DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_ADDR;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            count_reg       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                word_reg[i]    <= '0;
                slot_pc_reg[i] <= '0;
            end
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_pc_reg <= inflight_pc_next;
            inflight_reg    <= inflight_next;
            count_reg       <= count_next;
            for (int i = 0; i < 2; i++) begin
                word_reg[i]    <= word_next[i];
                slot_pc_reg[i] <= slot_pc_next[i];
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_count_reg, stall_count_next;

    assign stall_count = stall_count_reg;

    // Saturating count of cycles where decode refuses a valid word.
    always_comb begin
        stall_count_next = stall_count_reg;
        if (redirect_valid) begin
            stall_count_next = 16'd0;
        end else if (instr_valid && !instr_ready && (stall_count_reg != 16'hFFFF)) begin
            stall_count_next = stall_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg <= 16'd0;
        end else begin
            stall_count_reg <= stall_count_next;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset stream, backpressure, redirect,
// PC wrap, halt drain and asynchronous reset; stall counter when FETCH_STALL_CNT_EN is set.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [11:0] mem_addr;
    logic [11:0] mem_data;
    logic        halt;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr;
    logic [11:0] instr_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_pc;
    logic [11:0] held_addr;

    fetch_unit #(
        .DATA_WIDTH (12),
        .RESET_PC   (32'h010)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
`ifdef FETCH_STALL_CNT_EN
        .instr_pc       (instr_pc),
        .stall_count    (stall_count)
`else
        .instr_pc       (instr_pc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program memory model: registered read, word = 0xA00 | address.
    always @(posedge clk) begin
        mem_data <= 12'hA00 | mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input logic [11:0] pc);
        check("head_valid", 32'(instr_valid), 32'd1);
        check("head_pc", 32'(instr_pc), 32'(pc));
        check("head_word", 32'(instr), 32'(12'hA00 | pc));
        $display("head pc=%03h instr=%03h valid=%0b ready=%0b", instr_pc, instr, instr_valid, instr_ready);
    endtask

    // Buffer must never be pushed while full (a push with two words held and no pop).
    always @(negedge clk) begin
        if (!rst) begin
            check("no_overflow",
                  32'(dut.inflight_reg && (dut.count_reg == 2'd2) &&
                      !(instr_valid && instr_ready) && !redirect_valid),
                  32'd0);
        end
    end

    initial begin
        rst            = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        instr_ready    = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'h010);
        check("rst_instr", 32'(instr), 32'h000);
        check("rst_instr_pc", 32'(instr_pc), 32'h000);
        tick();
        tick();
        check("rst_addr_held", 32'(mem_addr), 32'h010);
        rst = 1'b0;

        // First word: issue at edge 1, valid after edge 2.
        tick();
        check("edge1_valid", 32'(instr_valid), 32'd0);
        check("edge1_addr", 32'(mem_addr), 32'h011);
        tick();
        exp_pc = 12'h010;
        repeat (4) begin
            expect_head(exp_pc);
            tick();
            exp_pc = exp_pc + 12'd1;
        end

        // Backpressure: head holds and fetch address freezes.
        instr_ready = 1'b0;
        expect_head(exp_pc);
        held_addr = exp_pc + 12'd2;
        check("bp_addr", 32'(mem_addr), 32'(held_addr));
        repeat (5) begin
            tick();
            expect_head(exp_pc);
            check("bp_addr_frozen", 32'(mem_addr), 32'(held_addr));
        end
        instr_ready = 1'b1;
        repeat (4) begin
            expect_head(exp_pc);
            tick();
            exp_pc = exp_pc + 12'd1;
        end

        // Redirect with an in-cycle transfer of the current head.
        expect_head(exp_pc);
        redirect_valid = 1'b1;
        redirect_pc    = 12'h7F0;
        tick();
        redirect_valid = 1'b0;
        check("redir_n_valid", 32'(instr_valid), 32'd0);
        check("redir_n_addr", 32'(mem_addr), 32'h7F0);
        tick();
        check("redir_n1_valid", 32'(instr_valid), 32'd0);
        check("redir_n1_addr", 32'(mem_addr), 32'h7F1);
        tick();
        exp_pc = 12'h7F0;
        repeat (3) begin
            expect_head(exp_pc);
            tick();
            exp_pc = exp_pc + 12'd1;
        end

        // PC wrap past 0xFFF.
        expect_head(exp_pc);
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_n_valid", 32'(instr_valid), 32'd0);
        tick();
        tick();
        expect_head(12'hFFE);
        tick();
        expect_head(12'hFFF);
        tick();
        expect_head(12'h000);
        tick();
        expect_head(12'h001);
        tick();
        exp_pc = 12'h002;

        // Halt: in-flight and buffered words drain, address holds.
        halt = 1'b1;
        expect_head(exp_pc);
        held_addr = exp_pc + 12'd2;
        check("halt_addr0", 32'(mem_addr), 32'(held_addr));
        tick();
        expect_head(exp_pc + 12'd1);
        check("halt_addr1", 32'(mem_addr), 32'(held_addr));
        tick();
        check("halt_drained", 32'(instr_valid), 32'd0);
        check("halt_addr2", 32'(mem_addr), 32'(held_addr));
        tick();
        check("halt_still_empty", 32'(instr_valid), 32'd0);
        check("halt_addr3", 32'(mem_addr), 32'(held_addr));

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        check("async_rst_addr", 32'(mem_addr), 32'h010);
        check("async_rst_instr", 32'(instr), 32'h000);
        check("async_rst_pc", 32'(instr_pc), 32'h000);

`ifdef FETCH_STALL_CNT_EN
        halt        = 1'b0;
        instr_ready = 1'b0;
        tick();
        check("stall_rst", 32'(stall_count), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("stall_first_valid", 32'(instr_valid), 32'd1);
        check("stall_start", 32'(stall_count), 32'd0);
        repeat (7) tick();
        check("stall_seven", 32'(stall_count), 32'd7);
        expect_head(12'h010);
        redirect_valid = 1'b1;
        redirect_pc    = 12'h100;
        tick();
        redirect_valid = 1'b0;
        check("stall_cleared", 32'(stall_count), 32'd0);
        check("stall_redir_valid", 32'(instr_valid), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
